// File: rtl/prim_assembler_pkg.sv
// rtl/prim_assembler_pkg.sv - header layout, modes, states and slot sequencing for the primitive assembler
package prim_assembler_pkg;

  localparam logic [3:0] PRIM_HDR_MARKER = 4'hB;
  localparam int         HDR_MARK_LSB    = 28;
  localparam int         HDR_MODE_LSB    = 26;

  typedef enum logic [1:0] {LIST, STRIP, FAN, RSVD} prim_mode_t;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} pa_state_t;

  // Fan keeps vertex 0 pinned in slot 0 and ping-pongs the rest between slots 1 and 2.
  function automatic logic [1:0] next_slot(input prim_mode_t mode, input logic [1:0] slot);
    if (mode == FAN) return (slot == 2'd1) ? 2'd2 : 2'd1;
    return (slot == 2'd2) ? 2'd0 : slot + 2'd1;
  endfunction

endpackage

// File: rtl/prim_assembler_if.sv
// rtl/prim_assembler_if.sv - vertex input stream and triangle output stream
interface prim_assembler_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/prim_assembler_vertex_store.sv
// rtl/prim_assembler_vertex_store.sv - three-slot vertex register file, one write port, one async read port
module prim_vertex_store #(
  parameter int DATA_W     = 32,
  parameter int VERT_WORDS = 4,
  parameter int WORD_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        wr_slot,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_slot,
  input  logic [WORD_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [3][VERT_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        for (int w = 0; w < VERT_WORDS; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else if (we && wr_slot != 2'd3) begin
      mem[wr_slot][wr_word] <= wr_data;
    end
  end

  assign rd_data = (rd_slot == 2'd3) ? '0 : mem[rd_slot][rd_word];

endmodule

// File: rtl/prim_assembler.sv
// rtl/prim_assembler.sv - assembles list/strip/fan triangles from headed vertex batches
module prim_assembler
  import prim_assembler_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int VERT_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  prim_assembler_if.slave  strm,
  output logic             busy,
  output logic             bad_hdr,
  output logic [CNT_W-1:0] tri_count
);

  localparam int WORD_W = (VERT_WORDS > 1) ? $clog2(VERT_WORDS) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(VERT_WORDS - 1);

  pa_state_t         state_q, state_d;
  prim_mode_t        mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  vtx_idx;
  logic [WORD_W-1:0] wcnt;
  logic [1:0]        wr_slot;
  logic [1:0]        emit_slot;
  logic              emit_odd;
  logic [1:0]        e_vert;
  logic [WORD_W-1:0] e_word;
  logic              in_ready_c;
  logic              out_valid_c;
  logic [1:0]        slot_a, slot_b, rd_slot;
  logic [1:0]        prev1, prev2;
  logic [DATA_W-1:0] rd_data;

  wire in_fire   = strm.in_valid && strm.in_ready;
  wire out_fire  = strm.out_valid && strm.out_ready;
  wire last_word = (wcnt == LAST_WORD);
  wire emit_last = (e_word == LAST_WORD) && (e_vert == 2'd2);

  wire               hdr_mark_ok = (strm.in_data[HDR_MARK_LSB +: 4] == PRIM_HDR_MARKER);
  wire prim_mode_t   hdr_mode    = prim_mode_t'(strm.in_data[HDR_MODE_LSB +: 2]);
  wire [CNT_W-1:0]   hdr_cnt     = strm.in_data[CNT_W-1:0];
  wire               hdr_ok      = hdr_mark_ok && (hdr_mode != RSVD);

  logic tri_due;
  always_comb begin
    tri_due = 1'b0;
    case (mode_q)
      LIST:       tri_due = (wr_slot == 2'd2);
      STRIP, FAN: tri_due = (vtx_idx >= CNT_W'(2));
      default:    tri_due = 1'b0;
    endcase
  end

  wire batch_last = (vtx_idx + CNT_W'(1) == cnt_q);
  wire batch_done = (vtx_idx == cnt_q);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (strm.in_valid && hdr_ok && hdr_cnt != '0) state_d = LOAD;
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (strm.in_valid && last_word) begin
          if (tri_due)         state_d = EMIT;
          else if (batch_last) state_d = IDLE;
        end
      end
      EMIT: begin
        out_valid_c = 1'b1;
        if (strm.out_ready && emit_last) state_d = batch_done ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mode_q    <= LIST;
      cnt_q     <= '0;
      vtx_idx   <= '0;
      wcnt      <= '0;
      wr_slot   <= 2'd0;
      emit_slot <= 2'd0;
      emit_odd  <= 1'b0;
      e_vert    <= 2'd0;
      e_word    <= '0;
      bad_hdr   <= 1'b0;
      tri_count <= '0;
    end else begin
      bad_hdr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            if (!hdr_ok) begin
              bad_hdr <= 1'b1;
            end else if (hdr_cnt != '0) begin
              mode_q    <= hdr_mode;
              cnt_q     <= hdr_cnt;
              tri_count <= '0;
              vtx_idx   <= '0;
              wcnt      <= '0;
              wr_slot   <= 2'd0;
            end
          end
        end
        LOAD: begin
          if (in_fire) begin
            if (last_word) begin
              wcnt      <= '0;
              vtx_idx   <= vtx_idx + CNT_W'(1);
              emit_slot <= wr_slot;
              emit_odd  <= vtx_idx[0];
              wr_slot   <= next_slot(mode_q, wr_slot);
              e_vert    <= 2'd0;
              e_word    <= '0;
            end else begin
              wcnt <= wcnt + WORD_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (e_word == LAST_WORD) begin
              e_word <= '0;
              if (e_vert == 2'd2) begin
                e_vert <= 2'd0;
                if (tri_count != '1) tri_count <= tri_count + CNT_W'(1);
              end else begin
                e_vert <= e_vert + 2'd1;
              end
            end else begin
              e_word <= e_word + WORD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // emit_slot holds vertex k; list/strip neighbours are the two other slots in rotation order.
  always_comb begin
    prev1  = (emit_slot == 2'd0) ? 2'd2 : emit_slot - 2'd1;
    prev2  = (emit_slot == 2'd2) ? 2'd0 : emit_slot + 2'd1;
    slot_a = prev2;
    slot_b = prev1;
    case (mode_q)
      STRIP: if (emit_odd) begin
        slot_a = prev1;
        slot_b = prev2;
      end
      FAN: begin
        slot_a = 2'd0;
        slot_b = (emit_slot == 2'd1) ? 2'd2 : 2'd1;
      end
      default: ;
    endcase
    case (e_vert)
      2'd0:    rd_slot = slot_a;
      2'd1:    rd_slot = slot_b;
      default: rd_slot = emit_slot;
    endcase
  end

  prim_vertex_store #(
    .DATA_W     (DATA_W),
    .VERT_WORDS (VERT_WORDS),
    .WORD_W     (WORD_W)
  ) u_store (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .we      (in_fire && state_q == LOAD),
    .wr_slot (wr_slot),
    .wr_word (wcnt),
    .wr_data (strm.in_data),
    .rd_slot (rd_slot),
    .rd_word (e_word),
    .rd_data (rd_data)
  );

  assign strm.in_ready  = in_ready_c && reset_reset_n;
  assign strm.out_valid = out_valid_c;
  assign strm.out_data  = out_valid_c ? rd_data : '0;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_prim_assembler.sv
// tb/tb_prim_assembler.sv - directed self-checking bench for prim_assembler
module tb_prim_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic        bad_hdr;
  logic [15:0] tri_count;

  int checks = 0;
  int errors = 0;

  logic        rand_rdy = 1'b0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int          stab_viol = 0;
  int          overlap_viol = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev = '0;

  prim_assembler_if #(.DATA_W(32)) intf ();

  prim_assembler #(.DATA_W(32), .VERT_WORDS(4), .CNT_W(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .strm          (intf.slave),
    .busy          (busy),
    .bad_hdr       (bad_hdr),
    .tri_count     (tri_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) intf.out_ready = 1'($urandom_range(0, 1));
  end

  // Transfers are recorded mid-cycle; inputs only move just after the rising edge.
  always @(negedge clk) begin
    if (intf.out_valid && intf.in_ready) overlap_viol++;
    if (stall_prev && (!intf.out_valid || intf.out_data !== data_prev)) stab_viol++;
    if (intf.out_valid && intf.out_ready) got.push_back(intf.out_data);
    stall_prev = intf.out_valid && !intf.out_ready;
    data_prev  = intf.out_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int t = 0;
    intf.in_valid = 1'b1;
    intf.in_data  = w;
    while (!intf.in_ready && t < 300) begin
      step();
      t++;
    end
    step();
    intf.in_valid = 1'b0;
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed %0b, required 1", intf.in_ready);
    end
  endtask

  task automatic wait_idle(output bit timed_out);
    int t = 0;
    while (busy && t < 500) begin
      step();
      t++;
    end
    repeat (2) step();
    timed_out = (t >= 500);
  endtask

  task automatic exp_verts(input int v0, input int v1, input int v2);
    int vs[3];
    vs = '{v0, v1, v2};
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 4; w++) exp_q.push_back(32'(vs[i]));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    intf.in_valid = 1'b0;
    intf.in_data = '0;
    intf.out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #3;
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, want 0", intf.out_valid); end
    checks++; if (intf.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h, want 0", intf.out_data); end
    checks++; if (intf.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b, want 0", intf.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, want 0", busy); end
    checks++; if (bad_hdr !== 1'b0) begin errors++; $display("FAIL reset_bad_hdr: got %0b, want 0", bad_hdr); end
    checks++; if (tri_count !== 16'h0) begin errors++; $display("FAIL reset_tri_count: got %0d, want 0", tri_count); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checks++; if (intf.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b, want 1", intf.in_ready); end
  endtask

  task automatic test_list();
    bit to;
    got.delete(); exp_q.delete();
    push(32'hB000_0006);
    for (int i = 0; i < 24; i++) begin
      push(32'(i));
      if (i == 11) begin
        checks++; if (intf.out_valid !== 1'b1 || intf.in_ready !== 1'b0) begin
          errors++; $display("FAIL list_emit_start: out_valid=%0b in_ready=%0b, want 1/0", intf.out_valid, intf.in_ready);
        end
      end
    end
    wait_idle(to);
    for (int i = 0; i < 24; i++) exp_q.push_back(32'(i));
    checks++; if (to || got.size() != 24) begin errors++; $display("FAIL list_count: got %0d words, want 24", got.size()); end
    for (int i = 0; i < 24 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL list_word[%0d]: got %h, want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (tri_count !== 16'd2) begin errors++; $display("FAIL list_tri_count: got %0d, want 2", tri_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL list_busy: got %0b, want 0", busy); end
  endtask

  task automatic run_topo(input string name, input logic [31:0] hdr);
    bit to;
    got.delete();
    push(hdr);
    for (int v = 0; v < 5; v++)
      for (int w = 0; w < 4; w++) push(32'(v));
    wait_idle(to);
    checks++; if (to || got.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d words, want %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word[%0d]: got %h, want %h", name, i, got[i], exp_q[i]); end
    end
    checks++; if (tri_count !== 16'd3) begin errors++; $display("FAIL %s_tri_count: got %0d, want 3", name, tri_count); end
  endtask

  task automatic test_strip();
    exp_q.delete();
    exp_verts(0, 1, 2); exp_verts(2, 1, 3); exp_verts(2, 3, 4);
    run_topo("strip", 32'hB400_0005);
  endtask

  task automatic test_fan();
    exp_q.delete();
    exp_verts(0, 1, 2); exp_verts(0, 2, 3); exp_verts(0, 3, 4);
    run_topo("fan", 32'hB800_0005);
  endtask

  task automatic test_bad_hdr();
    logic [31:0] bad[2];
    bit to;
    bad = '{32'h1000_0003, 32'hBC00_0003};
    got.delete();
    for (int i = 0; i < 2; i++) begin
      push(bad[i]);
      checks++; if (bad_hdr !== 1'b1) begin errors++; $display("FAIL bad_hdr_pulse[%0d]: got %0b, want 1", i, bad_hdr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_hdr_busy[%0d]: got %0b, want 0", i, busy); end
      step();
      checks++; if (bad_hdr !== 1'b0) begin errors++; $display("FAIL bad_hdr_clear[%0d]: got %0b, want 0", i, bad_hdr); end
    end
    push(32'hB000_0000);
    checks++; if (busy !== 1'b0 || bad_hdr !== 1'b0) begin errors++; $display("FAIL zero_count: busy=%0b bad_hdr=%0b, want 0/0", busy, bad_hdr); end
    push(32'hB000_0002);
    for (int i = 0; i < 8; i++) push(32'h50 + 32'(i));
    wait_idle(to);
    checks++; if (to || got.size() != 0) begin errors++; $display("FAIL short_list_out: got %0d words, want 0", got.size()); end
    checks++; if (tri_count !== 16'd0) begin errors++; $display("FAIL short_list_tri_count: got %0d, want 0", tri_count); end
    checks++; if (intf.in_ready !== 1'b1) begin errors++; $display("FAIL short_list_in_ready: got %0b, want 1", intf.in_ready); end
  endtask

  task automatic test_backpressure();
    bit to;
    got.delete(); exp_q.delete();
    stab_viol = 0; overlap_viol = 0;
    rand_rdy = 1'b1;
    push(32'hB000_0003);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) step();
      push(32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
    end
    wait_idle(to);
    rand_rdy = 1'b0;
    step();
    intf.out_ready = 1'b1;
    checks++; if (to || got.size() != 12) begin errors++; $display("FAIL bp_count: got %0d words, want 12", got.size()); end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h, want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d violations, want 0", stab_viol); end
    checks++; if (overlap_viol != 0) begin errors++; $display("FAIL bp_in_ready: got %0d overlap cycles, want 0", overlap_viol); end
    checks++; if (tri_count !== 16'd1) begin errors++; $display("FAIL bp_tri_count: got %0d, want 1", tri_count); end
  endtask

  task automatic test_reset_emit();
    bit to;
    intf.out_ready = 1'b1;
    push(32'hB000_0003);
    for (int i = 0; i < 12; i++) push(32'h200 + 32'(i));
    repeat (4) step();
    checks++; if (intf.out_valid !== 1'b1 || intf.out_data !== 32'h204) begin
      errors++; $display("FAIL emit5_pre: out_valid=%0b out_data=%h, want 1/00000204", intf.out_valid, intf.out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL rst_emit_out_valid: got %0b, want 0", intf.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_emit_busy: got %0b, want 0", busy); end
    checks++; if (tri_count !== 16'd0) begin errors++; $display("FAIL rst_emit_tri_count: got %0d, want 0", tri_count); end
    step();
    rst_n = 1'b1;
    step();
    got.delete(); exp_q.delete();
    push(32'hB000_0003);
    for (int i = 0; i < 12; i++) begin
      push(32'h300 + 32'(i));
      exp_q.push_back(32'h300 + 32'(i));
    end
    wait_idle(to);
    checks++; if (to || got.size() != 12) begin errors++; $display("FAIL post_rst_count: got %0d words, want 12", got.size()); end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL post_rst_word[%0d]: got %h, want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (tri_count !== 16'd1) begin errors++; $display("FAIL post_rst_tri_count: got %0d, want 1", tri_count); end
  endtask

  initial begin
    test_reset();
    test_list();
    test_strip();
    test_fan();
    test_bad_hdr();
    test_backpressure();
    test_reset_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
